// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces the first key
// found, emits its {row, col} code with a one-cycle strobe, then waits for a clean release.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] button,
  output logic       is_pressed_next
);

  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {StScan, StDebounce, StPress, StHold, StRelease} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [3:0]      button_q, button_d;
  logic            strobe_q, strobe_d;

  logic [3:0]      row_low;
  logic            sel_low;
  logic [1:0]      first_row;

  assign row_low = ~sync2_q;
  assign sel_low = row_low[row_idx_q];

  // Lowest-numbered active row wins when several keys share a column.
  always_comb begin
    first_row = 2'd3;
    if (row_low[0])      first_row = 2'd0;
    else if (row_low[1]) first_row = 2'd1;
    else if (row_low[2]) first_row = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_d      = col_q;
    row_idx_d  = row_idx_q;
    button_d   = button_q;
    strobe_d   = 1'b0;
    case (state_q)
      StScan: begin
        if (scan_cnt_q >= SCAN_LAST) begin
          scan_cnt_d = '0;
          if (|row_low) begin
            row_idx_d = first_row;
            deb_cnt_d = '0;
            state_d   = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      StDebounce: begin
        if (!sel_low) begin
          scan_cnt_d = '0;
          state_d    = StScan;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d = StPress;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      StPress: begin
        button_d = {row_idx_q, col_q};
        strobe_d = 1'b1;
        state_d  = StHold;
      end
      StHold: begin
        if (!sel_low) begin
          deb_cnt_d = '0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (sel_low) begin
          state_d = StHold;
        end else if (deb_cnt_q >= DEB_LAST) begin
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          state_d    = StScan;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      state_q    <= StScan;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_q      <= 2'd0;
      row_idx_q  <= 2'd0;
      button_q   <= 4'h0;
      strobe_q   <= 1'b0;
    end else begin
      sync1_q    <= row_n;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      col_q      <= col_d;
      row_idx_q  <= row_idx_d;
      button_q   <= button_d;
      strobe_q   <= strobe_d;
    end
  end

  assign col_n           = ~(4'b0001 << col_q);
  assign button          = button_q;
  assign is_pressed_next = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 switch-matrix model closes rows against the driven column;
// expected codes are queued at key-press time and checked against each strobe.
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  button;
  logic        is_pressed_next;

  logic [15:0] keys;
  logic [3:0]  sb[$];
  int          vectors;
  int          miscompares;
  int          strobes;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .row_n          (row_n),
    .col_n          (col_n),
    .button         (button),
    .is_pressed_next(is_pressed_next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Switch matrix: a closed key pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clock) begin
    logic [3:0] exp_code;
    #1;
    if (is_pressed_next === 1'b1) begin
      strobes++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got strobe with button=%b, required no strobe", button);
      end else begin
        exp_code = sb.pop_front();
        if (button !== exp_code) begin
          miscompares++;
          $display("FAIL strobe_code: button=%b, required %b", button, exp_code);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] key_bit(input int r, input int c);
    return 16'h0001 << (r*4 + c);
  endfunction

  task automatic wait_for_strobe(input int budget, output bit got, output int cycles);
    int start;
    start  = strobes;
    cycles = 0;
    while (strobes == start && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    got = (strobes != start);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(negedge clock);
    vectors++;
    if (col_n !== 4'b1110) begin
      miscompares++; $display("FAIL reset_col: col_n=%b, required 1110", col_n);
    end
    vectors++;
    if (button !== 4'h0) begin
      miscompares++; $display("FAIL reset_button: button=%b, required 0000", button);
    end
    vectors++;
    if (is_pressed_next !== 1'b0) begin
      miscompares++; $display("FAIL reset_strobe: strobe=%b, required 0", is_pressed_next);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      vectors++;
      if (col_n !== exp_col) begin
        miscompares++;
        $display("FAIL idle_scan: cycle %0d col_n=%b, required %b", k, col_n, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    bit got;
    int n;
    @(negedge clock);
    keys = key_bit(2, 1);
    sb.push_back(4'b1001);
    wait_for_strobe(28, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL clean_press_latency: no strobe in %0d cycles, required one", n);
    end
    for (int i = n; i < 40; i++) begin
      @(negedge clock);
      vectors++;
      if (col_n !== 4'b1101) begin
        miscompares++; $display("FAIL clean_press_col_hold: col_n=%b, required 1101", col_n);
      end
    end
    keys = '0;
    idle(5);
    vectors++;
    if (col_n !== 4'b1101) begin
      miscompares++; $display("FAIL clean_release_early: col_n=%b, required 1101", col_n);
    end
    n = 0;
    while (col_n === 4'b1101 && n < 20) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (col_n !== 4'b1011) begin
      miscompares++; $display("FAIL clean_release_next_col: col_n=%b, required 1011", col_n);
    end
    vectors++;
    if (button !== 4'b1001) begin
      miscompares++; $display("FAIL button_hold: button=%b, required 1001", button);
    end
  endtask

  task automatic test_bounce();
    bit got;
    int n;
    @(negedge clock);
    for (int i = 0; i < 30; i++) begin
      keys = (((i / 3) % 2) == 0) ? key_bit(0, 2) : 16'h0000;
      @(negedge clock);
    end
    keys = key_bit(0, 2);
    sb.push_back(4'b0010);
    wait_for_strobe(28, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL bounce_press: no strobe in %0d cycles, required one", n);
    end
    idle(10);
    keys = '0;
    idle(30);
  endtask

  task automatic test_long_hold();
    bit got;
    int n;
    @(negedge clock);
    keys = key_bit(3, 3);
    sb.push_back(4'b1111);
    wait_for_strobe(28, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL long_hold_press: no strobe in %0d cycles, required one", n);
    end
    idle(500 - n);
    vectors++;
    if (col_n !== 4'b0111) begin
      miscompares++; $display("FAIL long_hold_col: col_n=%b, required 0111", col_n);
    end
    for (int i = 0; i < 5; i++) begin
      keys = ((i % 2) == 0) ? 16'h0000 : key_bit(3, 3);
      @(negedge clock);
    end
    keys = '0;
    vectors++;
    if (col_n !== 4'b0111) begin
      miscompares++; $display("FAIL release_bounce_col: col_n=%b, required 0111", col_n);
    end
    n = 0;
    while (col_n === 4'b0111 && n < 20) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n < 8) begin
      miscompares++; $display("FAIL release_too_fast: scan resumed after %0d cycles, required >= 8", n);
    end
    vectors++;
    if (col_n !== 4'b1110) begin
      miscompares++; $display("FAIL release_next_col: col_n=%b, required 1110", col_n);
    end
  endtask

  task automatic test_two_keys();
    bit got;
    int n;
    @(negedge clock);
    keys = key_bit(1, 0) | key_bit(3, 0);
    sb.push_back(4'b0100);
    wait_for_strobe(28, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL two_keys_press: no strobe in %0d cycles, required one", n);
    end
    keys = keys | key_bit(0, 2);
    idle(30);
    vectors++;
    if (col_n !== 4'b1110) begin
      miscompares++; $display("FAIL two_keys_col_hold: col_n=%b, required 1110", col_n);
    end
    keys = key_bit(3, 0);
    sb.push_back(4'b1100);
    wait_for_strobe(60, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL two_keys_second: no strobe in %0d cycles, required one", n);
    end
    keys = '0;
    idle(30);
  endtask

  task automatic test_reset_in_hold();
    bit got;
    int n;
    @(negedge clock);
    keys = key_bit(0, 1);
    sb.push_back(4'b0001);
    wait_for_strobe(28, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL hold_press: no strobe in %0d cycles, required one", n);
    end
    idle(5);
    reset = 1'b1;
    #1;
    vectors++;
    if (col_n !== 4'b1110) begin
      miscompares++; $display("FAIL hold_reset_col: col_n=%b, required 1110", col_n);
    end
    vectors++;
    if (button !== 4'h0) begin
      miscompares++; $display("FAIL hold_reset_button: button=%b, required 0000", button);
    end
    vectors++;
    if (is_pressed_next !== 1'b0) begin
      miscompares++; $display("FAIL hold_reset_strobe: strobe=%b, required 0", is_pressed_next);
    end
    idle(3);
    reset = 1'b0;
    sb.push_back(4'b0001);
    wait_for_strobe(40, got, n);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL hold_repress: no strobe in %0d cycles, required one", n);
    end
    keys = '0;
    idle(30);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    strobes     = 0;
    keys        = '0;
    reset       = 1'b1;
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_two_keys();
    test_reset_in_hold();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL pending_codes: %0d codes never strobed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
